// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a single-port SRAM. Reads take priority over writes,
// and a two-entry output buffer absorbs the one-cycle SRAM read latency.
module sram_fifo_ctrl #(
    parameter int unsigned ADDR  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [ADDR-1:0]  sram_addr,
    output logic [WIDTH-1:0] sram_data_in,
    output logic             sram_write_en,
    input  logic [WIDTH-1:0] sram_data_out,
    output logic [ADDR+1:0]  count,
    output logic             full
);

    localparam logic [ADDR:0] FullCount = {1'b1, {ADDR{1'b0}}};

    logic [ADDR:0]    wr_ptr_q, rd_ptr_q, mem_count;
    logic             inflight_q;
    logic [WIDTH-1:0] obuf_q [2];
    logic [WIDTH-1:0] obuf_d [2];
    logic [1:0]       obuf_cnt_q, obuf_cnt_d;
    logic [1:0]       occ;
    logic             rd_issue, push, pop;

    // The wrap bit separates full from empty when the low pointer bits match.
    assign mem_count = wr_ptr_q - rd_ptr_q;
    assign occ       = obuf_cnt_q + {1'b0, inflight_q};
    assign full      = (mem_count == FullCount);
    assign rd_issue  = (mem_count != '0) && (occ < 2'd2);
    assign in_ready  = !full && !rd_issue && rst_n;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign sram_addr     = rd_issue ? rd_ptr_q[ADDR-1:0] : wr_ptr_q[ADDR-1:0];
    assign sram_write_en = push;
    assign sram_data_in  = in_data;

    assign out_valid = (obuf_cnt_q != 2'd0);
    assign out_data  = obuf_q[0];
    assign count     = (ADDR+2)'(mem_count) + (ADDR+2)'(inflight_q) + (ADDR+2)'(obuf_cnt_q);

    // Pop first, then append behind whatever remains. Reads are only issued while
    // occ < 2, so an append never finds the buffer already holding two words.
    always_comb begin
        obuf_d     = obuf_q;
        obuf_cnt_d = obuf_cnt_q;
        if (pop) begin
            if (obuf_cnt_q == 2'd2) begin
                obuf_d[0] = obuf_q[1];
            end
            obuf_cnt_d = obuf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (obuf_cnt_d == 2'd0) begin
                obuf_d[0] = sram_data_out;
            end else begin
                obuf_d[1] = sram_data_out;
            end
            obuf_cnt_d = obuf_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            obuf_cnt_q <= 2'd0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            inflight_q <= rd_issue;
            obuf_cnt_q <= obuf_cnt_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural single-port SRAM and an
// in-order scoreboard of accepted words.
module tb_sram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  sram_addr;
    logic [31:0] sram_data_in;
    logic        sram_write_en;
    logic [31:0] sram_data_out;
    logic [5:0]  count;
    logic        full;

    logic [31:0] mem [16];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q [$];
    int          wr_cnt = 0;
    int          popped = 0;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_we;
        logic [3:0]  e_addr;
        logic        e_ov;
        logic [31:0] e_od;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [5];

    sram_fifo_ctrl #(
        .ADDR (4),
        .WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .sram_addr    (sram_addr),
        .sram_data_in (sram_data_in),
        .sram_write_en(sram_write_en),
        .sram_data_out(sram_data_out),
        .count        (count),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: write or registered read, one per cycle.
    always_ff @(posedge clk) begin
        if (sram_write_en) begin
            mem[sram_addr] <= sram_data_in;
        end else begin
            sram_data_out <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle with scoreboard bookkeeping; inputs must already be driven.
    task automatic cycle(output bit acc);
        bit          p;
        bit          o;
        logic [31:0] exp;
        #1;
        if (sram_write_en) begin
            check("wr_addr", 32'(sram_addr), 32'(wr_cnt % 16));
            check("wr_needs_valid", 32'(in_valid), 32'd1);
        end
        p = in_valid && in_ready;
        o = out_valid && out_ready;
        if (o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no word", out_data);
            end else begin
                exp = q.pop_front();
                check("pop_data", out_data, exp);
                popped++;
            end
        end
        if (p) begin
            q.push_back(in_data);
            wr_cnt++;
        end
        acc = p;
        @(posedge clk);
        #1;
        check("count_track", 32'(count), 32'(q.size()));
        check("count_max", 32'(count > 6'd18), 32'd0);
    endtask

    task automatic push_word(input logic [31:0] d, output bit ok, output int waits);
        bit acc;
        in_data  = d;
        in_valid = 1'b1;
        waits    = 0;
        cycle(acc);
        while (!acc && waits < 12) begin
            waits++;
            cycle(acc);
        end
        ok       = acc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 300) begin
            cycle(acc);
            n++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'd0;
        #1 rst_n  = 1'b0;
        q.delete();
        wr_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        bit acc;
        int w;
        int n;
        int accepted;
        int max_w;
        int idx;
        int pop0;

        // Single word end to end: write addr 0, read addr 0, visible after T+2.
        tbl[0] = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 6'd0};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 6'd1};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 32'h0, 6'd1};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 32'h1, 6'd1};
        tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 32'h1, 6'd0};

        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_write_en", 32'(sram_write_en), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_write_en", i), 32'(sram_write_en), 32'(tbl[i].e_we));
            check($sformatf("tbl%0d_addr", i), 32'(sram_addr), 32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Fill with no pops: SRAM plus output buffer hold 18 words.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            push_word(32'(i), ok, w);
            if (ok) accepted++;
        end
        #1;
        check("fill_accepted", 32'(accepted), 32'd18);
        check("fill_count", 32'(count), 32'd18);
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        drain();
        check("fill_drain_full", 32'(full), 32'd0);

        // Pop and capture of the in-flight word on the same edge.
        do_reset();
        push_word(32'hA5A5_0001, ok, w);
        check("sim_push_a", 32'(ok), 32'd1);
        push_word(32'hA5A5_0002, ok, w);
        check("sim_push_b_wait", 32'(w), 32'd1);
        #1;
        check("sim_rd_in_ready", 32'(in_ready), 32'd0);
        check("sim_rd_addr", 32'(sram_addr), 32'd1);
        cycle(acc);
        check("sim_head_a", out_data, 32'hA5A5_0001);
        check("sim_count2", 32'(count), 32'd2);
        out_ready = 1'b1;
        cycle(acc);
        check("sim_valid_b", 32'(out_valid), 32'd1);
        check("sim_head_b", out_data, 32'hA5A5_0002);
        check("sim_count1", 32'(count), 32'd1);
        drain();

        // Streaming through two pointer wraps.
        do_reset();
        out_ready = 1'b1;
        pop0      = popped;
        max_w     = 0;
        for (int i = 0; i < 40; i++) begin
            push_word(32'(i), ok, w);
            if (w > max_w) max_w = w;
        end
        check("wrap_all_accepted", 32'(wr_cnt), 32'd40);
        check("wrap_max_stall", 32'(max_w), 32'd1);
        drain();
        check("wrap_popped", 32'(popped - pop0), 32'd40);

        // Random traffic.
        do_reset();
        idx = 0;
        n   = 0;
        while ((idx < 1000 || q.size() > 0) && n < 30000) begin
            in_valid  = (idx < 1000) && ($urandom_range(0, 1) == 1);
            in_data   = 32'(idx);
            out_ready = ($urandom_range(0, 1) == 1);
            cycle(acc);
            if (acc) idx++;
            n++;
        end
        check("rand_pushed", 32'(idx), 32'd1000);
        check("rand_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_word(32'h100 + 32'(i), ok, w);
        end
        check("mid_count5", 32'(count), 32'd5);
        in_valid = 1'b1;
        in_data  = 32'h99;
        #2 rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd0);
        check("mid_write_en", 32'(sram_write_en), 32'd0);
        check("mid_out_data", out_data, 32'd0);
        q.delete();
        wr_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        pop0      = popped;
        out_ready = 1'b1;
        push_word(32'hC0FF_EE01, ok, w);
        check("mid_push_ok", 32'(ok), 32'd1);
        drain();
        check("mid_popped", 32'(popped - pop0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
